// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix scheduler: FSM state encoding and the
// flat-matrix element layout helpers.
package matrix_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DRAIN = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_DRAIN = ST_DRAIN,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_DONE  = ST_DONE
  } state_e;

  // Element (i,k) lives at flat index i*size+k, bit offset index*cell_width.
  function automatic int elem_index(input int i, input int k, input int size);
    return i * size + k;
  endfunction

  function automatic int elem_offset(input int i, input int k, input int size,
                                     input int cell_width);
    return elem_index(i, k, size) * cell_width;
  endfunction

endpackage

// File: rtl/matrix_scheduler_operand_select.sv
// Combinational slice of row i of A and column j of B out of the flat
// latched operand matrices.
module operand_select
  import matrix_pkg::*;
#(
  parameter int size       = 4,
  parameter int cell_width = 32,
  parameter int width      = cell_width * size,
  parameter int mat_width  = width * size,
  parameter int idx_w      = (size > 1) ? $clog2(size) : 1
) (
  input  logic [mat_width-1:0] mat_a_i,
  input  logic [mat_width-1:0] mat_b_i,
  input  logic [idx_w-1:0]     row_idx_i,
  input  logic [idx_w-1:0]     col_idx_i,
  output logic [width-1:0]     row_a_o,
  output logic [width-1:0]     col_b_o
);

  logic [cell_width-1:0] a_el [size][size];
  logic [cell_width-1:0] b_el [size][size];

  for (genvar gi = 0; gi < size; gi++) begin : g_row
    for (genvar gk = 0; gk < size; gk++) begin : g_el
      assign a_el[gi][gk] = mat_a_i[elem_offset(gi, gk, size, cell_width) +: cell_width];
      assign b_el[gi][gk] = mat_b_i[elem_offset(gi, gk, size, cell_width) +: cell_width];
    end
  end

  // Slot k carries A(i,k) and B(k,j) so the processor pairs them directly.
  for (genvar gk = 0; gk < size; gk++) begin : g_slot
    assign row_a_o[gk*cell_width +: cell_width] = a_el[row_idx_i][gk];
    assign col_b_o[gk*cell_width +: cell_width] = b_el[gk][col_idx_i];
  end

endmodule

// File: rtl/matrix_scheduler.sv
// Walks one column_processor over every cell of C = A*B in row-major order,
// capturing each result into a flat C register, with a done/ack handshake.
module matrix_scheduler
  import matrix_pkg::*;
#(
  parameter int size       = 4,
  parameter int cell_width = 32,
  parameter int width      = cell_width * size,
  parameter int mat_width  = width * size
) (
  input  logic                 in_clk,
  input  logic                 in_reset,
  input  logic                 in_start,
  input  logic [mat_width-1:0] in_mat_a,
  input  logic [mat_width-1:0] in_mat_b,
  input  logic                 in_done_ack,
  output logic [mat_width-1:0] out_mat_c,
  output logic                 out_done,
  output logic                 out_busy,
  output logic [width-1:0]     out_pe_row_a,
  output logic [width-1:0]     out_pe_col_b,
  output logic                 out_pe_ready,
  output logic                 out_pe_ack,
  input  logic [width-1:0]     in_pe_cell_c,
  input  logic                 in_pe_ready
);

  localparam int idx_w = (size > 1) ? $clog2(size) : 1;
  localparam logic [idx_w-1:0] last_idx = idx_w'(size - 1);

  state_e                 state_q;
  logic [mat_width-1:0]   a_q, b_q, mat_c_q;
  logic [idx_w-1:0]       i_q, j_q, i_d, j_d;
  logic                   done_q, busy_q, pe_ready_q, pe_ack_q;
  logic [width-1:0]       row_a_q, col_b_q, sel_row, sel_col;
  logic [size*size-1:0]   cell_we;
  logic                   last_cell;
  logic                   pe_cell_unused;

  operand_select #(
    .size       (size),
    .cell_width (cell_width),
    .width      (width),
    .mat_width  (mat_width),
    .idx_w      (idx_w)
  ) u_operand_select (
    .mat_a_i   (a_q),
    .mat_b_i   (b_q),
    .row_idx_i (i_q),
    .col_idx_i (j_q),
    .row_a_o   (sel_row),
    .col_b_o   (sel_col)
  );

  // Row-major advance: j wraps to 0 and carries into i.
  always_comb begin
    j_d = j_q + idx_w'(1);
    i_d = i_q;
    if (j_q == last_idx) begin
      j_d = '0;
      i_d = (i_q == last_idx) ? '0 : i_q + idx_w'(1);
    end
  end

  assign last_cell = (i_q == last_idx) && (j_q == last_idx);

  for (genvar gi = 0; gi < size; gi++) begin : g_we_row
    for (genvar gj = 0; gj < size; gj++) begin : g_we_col
      assign cell_we[elem_index(gi, gj, size)] = (i_q == idx_w'(gi)) && (j_q == idx_w'(gj));
    end
  end

  // Only the low cell_width bits of the processor result are meaningful.
  assign pe_cell_unused = ^in_pe_cell_c[width-1:cell_width];

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      mat_c_q    <= '0;
      i_q        <= '0;
      j_q        <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      row_a_q    <= '0;
      col_b_q    <= '0;
      pe_ready_q <= 1'b0;
      pe_ack_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_start) begin
            a_q     <= in_mat_a;
            b_q     <= in_mat_b;
            i_q     <= '0;
            j_q     <= '0;
            mat_c_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (in_pe_ready) begin
            pe_ack_q <= 1'b1;
          end else begin
            pe_ack_q <= 1'b0;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          row_a_q    <= sel_row;
          col_b_q    <= sel_col;
          pe_ready_q <= 1'b1;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          pe_ready_q <= 1'b0;
          if (in_pe_ready) begin
            for (int n = 0; n < size * size; n++) begin
              if (cell_we[n]) begin
                mat_c_q[n*cell_width +: cell_width] <= in_pe_cell_c[cell_width-1:0];
              end
            end
            pe_ack_q <= 1'b1;
            i_q      <= i_d;
            j_q      <= j_d;
            state_q  <= last_cell ? S_DONE : S_DRAIN;
          end
        end
        S_DONE: begin
          // The last result must be drained before done is offered or released.
          if (in_pe_ready) begin
            pe_ack_q <= 1'b1;
          end else begin
            pe_ack_q <= 1'b0;
            if (done_q && in_done_ack) begin
              done_q  <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_mat_c    = mat_c_q;
  assign out_done     = done_q;
  assign out_busy     = busy_q;
  assign out_pe_row_a = row_a_q;
  assign out_pe_col_b = col_b_q;
  assign out_pe_ready = pe_ready_q;
  assign out_pe_ack   = pe_ack_q;

endmodule

// File: tb/tb_matrix_scheduler.sv
// Self-checking bench for matrix_scheduler with a behavioural column
// processor and a plain-loop matrix product reference.
module tb_matrix_scheduler;

  localparam int SZ = 4;
  localparam int CW = 32;
  localparam int W  = CW * SZ;
  localparam int MW = W * SZ;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          done_ack = 1'b0;
  logic [MW-1:0] mat_a = '0;
  logic [MW-1:0] mat_b = '0;
  logic [MW-1:0] mat_c;
  logic          done, busy, pe_ready, pe_ack;
  logic [W-1:0]  row_a, col_b;
  logic          pm_ready = 1'b0;
  logic [W-1:0]  pm_cell = '0;

  int n_cmp = 0;
  int n_bad = 0;

  matrix_scheduler #(.size(SZ), .cell_width(CW)) dut (
    .in_clk       (clk),
    .in_reset     (rst),
    .in_start     (start),
    .in_mat_a     (mat_a),
    .in_mat_b     (mat_b),
    .in_done_ack  (done_ack),
    .out_mat_c    (mat_c),
    .out_done     (done),
    .out_busy     (busy),
    .out_pe_row_a (row_a),
    .out_pe_col_b (col_b),
    .out_pe_ready (pe_ready),
    .out_pe_ack   (pe_ack),
    .in_pe_cell_c (pm_cell),
    .in_pe_ready  (pm_ready)
  );

  always #5 clk = ~clk;

  // ---------------- reference helpers ----------------
  function automatic logic [MW-1:0] ref_product(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW-1:0] c;
    logic [CW-1:0] acc;
    c = '0;
    for (int i = 0; i < SZ; i++)
      for (int j = 0; j < SZ; j++) begin
        acc = '0;
        for (int k = 0; k < SZ; k++)
          acc += a[(i*SZ+k)*CW +: CW] * b[(k*SZ+j)*CW +: CW];
        c[(i*SZ+j)*CW +: CW] = acc;
      end
    return c;
  endfunction

  function automatic logic [W-1:0] exp_row(input logic [MW-1:0] a, input int i);
    logic [W-1:0] r;
    for (int k = 0; k < SZ; k++) r[k*CW +: CW] = a[(i*SZ+k)*CW +: CW];
    return r;
  endfunction

  function automatic logic [W-1:0] exp_col(input logic [MW-1:0] b, input int j);
    logic [W-1:0] r;
    for (int k = 0; k < SZ; k++) r[k*CW +: CW] = b[(k*SZ+j)*CW +: CW];
    return r;
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] m;
    for (int n = 0; n < SZ*SZ; n++) m[n*CW +: CW] = $urandom();
    return m;
  endfunction

  function automatic logic [W-1:0] pm_compute(input logic [W-1:0] r, input logic [W-1:0] c);
    logic [CW-1:0] acc;
    acc = '0;
    for (int k = 0; k < SZ; k++) acc += r[k*CW +: CW] * c[k*CW +: CW];
    return {$urandom(), $urandom(), $urandom(), acc};
  endfunction

  // ---------------- monitor ----------------
  int          cyc = 0;
  logic [W-1:0] iss_row[$];
  logic [W-1:0] iss_col[$];
  bit          iss_idle[$];
  int          iss_cyc[$];
  int          ack_rise[$];
  logic        ack_prev = 1'b0;
  int          pm_state = 0;
  int          pm_cnt = 0;
  bit          pm_stale_req = 1'b0;
  bit          corrupt_en = 1'b0;
  int          corrupt_base = 0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst && pe_ready) begin
      iss_row.push_back(row_a);
      iss_col.push_back(col_b);
      iss_idle.push_back(pm_state == 0 && !pm_ready);
      iss_cyc.push_back(cyc);
    end
    if (pe_ack && !ack_prev) ack_rise.push_back(cyc);
    ack_prev = pe_ack;
  end

  // ---------------- behavioural column processor ----------------
  always @(posedge clk) begin
    case (pm_state)
      0: begin
        if (pm_stale_req) begin
          pm_ready <= 1'b1;
          pm_cell  <= {W{1'b1}};
          pm_state <= 2;
        end else if (pe_ready) begin
          if (corrupt_en && (iss_row.size() - corrupt_base == SZ*SZ))
            pm_cell <= {64'h0, 64'hDEAD_BEEF_0000_0001};
          else
            pm_cell <= pm_compute(row_a, col_b);
          pm_cnt   <= $urandom_range(3, 0);
          pm_state <= 1;
        end
      end
      1: begin
        if (pm_cnt == 0) begin
          pm_ready <= 1'b1;
          pm_state <= 2;
        end else begin
          pm_cnt <= pm_cnt - 1;
        end
      end
      default: begin
        if (pe_ack) begin
          pm_ready <= 1'b0;
          pm_state <= 0;
        end
      end
    endcase
  end

  // ---------------- drive helpers (no checking) ----------------
  task automatic start_product(input logic [MW-1:0] a, input logic [MW-1:0] b);
    @(negedge clk);
    mat_a = a;
    mat_b = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic release_done(output bit ok);
    done_ack = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (!done) begin
        ok = 1'b1;
        break;
      end
    end
    done_ack = 1'b0;
  endtask

  task automatic wait_issues(input int target, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      #1;
      if (iss_row.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (mat_c !== '0)    begin n_bad++; $display("FAIL reset_mat_c: got %h want 0", mat_c); end
    n_cmp++; if (done !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (row_a !== '0)    begin n_bad++; $display("FAIL reset_row_a: got %h want 0", row_a); end
    n_cmp++; if (col_b !== '0)    begin n_bad++; $display("FAIL reset_col_b: got %h want 0", col_b); end
    n_cmp++; if (pe_ready !== 1'b0) begin n_bad++; $display("FAIL reset_pe_ready: got %b want 0", pe_ready); end
    n_cmp++; if (pe_ack !== 1'b0) begin n_bad++; $display("FAIL reset_pe_ack: got %b want 0", pe_ack); end
    rst = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_identity();
    logic [MW-1:0] a, b, exp;
    int base;
    bit ok;
    a = '0; b = '0;
    for (int r = 0; r < SZ; r++)
      for (int c = 0; c < SZ; c++) begin
        a[(r*SZ+c)*CW +: CW] = (r == c) ? 32'd1 : 32'd0;
        b[(r*SZ+c)*CW +: CW] = r*4 + c;
      end
    exp = ref_product(a, b);
    base = iss_row.size();
    start_product(a, b);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL identity_busy_rise: got %b want 1", busy); end
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL identity_done: got timeout want out_done"); end
    for (int n = 0; n < SZ*SZ; n++) begin
      n_cmp++;
      if (mat_c[n*CW +: CW] !== b[n*CW +: CW] || exp[n*CW +: CW] !== b[n*CW +: CW]) begin
        n_bad++;
        $display("FAIL identity_c(%0d,%0d): got %h want %h", n/SZ, n%SZ, mat_c[n*CW +: CW], b[n*CW +: CW]);
      end
    end
    release_done(ok);
    n_cmp++; if (iss_row.size() - base != SZ*SZ) begin n_bad++; $display("FAIL identity_issue_count: got %0d want %0d", iss_row.size() - base, SZ*SZ); end
    for (int k = 0; k < SZ*SZ && base + k < iss_row.size(); k++) begin
      n_cmp++;
      if (iss_row[base+k] !== exp_row(a, k/SZ) || iss_col[base+k] !== exp_col(b, k%SZ)) begin
        n_bad++;
        $display("FAIL identity_order[%0d]: got row %h col %h want row %h col %h", k,
                 iss_row[base+k], iss_col[base+k], exp_row(a, k/SZ), exp_col(b, k%SZ));
      end
    end
    $display("product identity: %0d issues", iss_row.size() - base);
  endtask

  task automatic test_const_ack_delay();
    logic [MW-1:0] a, b;
    bit ok;
    for (int n = 0; n < SZ*SZ; n++) begin
      a[n*CW +: CW] = 32'd2;
      b[n*CW +: CW] = 32'd3;
    end
    start_product(a, b);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL const_done: got timeout want out_done"); end
    for (int n = 0; n < SZ*SZ; n++) begin
      n_cmp++;
      if (mat_c[n*CW +: CW] !== 32'h18) begin
        n_bad++;
        $display("FAIL const_c(%0d,%0d): got %h want 00000018", n/SZ, n%SZ, mat_c[n*CW +: CW]);
      end
    end
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL const_done_hold[%0d]: got %b want 1", t, done); end
    end
    release_done(ok);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL const_idle: got done %b busy %b want 0 0", done, busy); end
    $display("product const: C cells 0x18, ack after 5 cycles");
  endtask

  task automatic test_stale_ready();
    logic [MW-1:0] a, b, exp;
    int base, t0, first_ack;
    bit ok;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    pm_stale_req = 1'b1;
    @(negedge clk); pm_stale_req = 1'b0;
    a = rand_mat(); b = rand_mat(); exp = ref_product(a, b);
    base = iss_row.size();
    t0 = cyc;
    start_product(a, b);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stale_done: got timeout want out_done"); end
    for (int n = 0; n < SZ*SZ; n++) begin
      n_cmp++;
      if (mat_c[n*CW +: CW] !== exp[n*CW +: CW]) begin
        n_bad++;
        $display("FAIL stale_c(%0d,%0d): got %h want %h", n/SZ, n%SZ, mat_c[n*CW +: CW], exp[n*CW +: CW]);
      end
    end
    release_done(ok);
    first_ack = -1;
    foreach (ack_rise[q]) if (first_ack < 0 && ack_rise[q] >= t0) first_ack = ack_rise[q];
    n_cmp++;
    if (iss_row.size() <= base || first_ack < 0 || first_ack >= iss_cyc[base]) begin
      n_bad++;
      $display("FAIL stale_ack_first: got ack cycle %0d issue cycle %0d want ack before issue", first_ack,
               (iss_row.size() > base) ? iss_cyc[base] : -1);
    end
    n_cmp++; if (iss_row.size() - base != SZ*SZ) begin n_bad++; $display("FAIL stale_issue_count: got %0d want %0d", iss_row.size() - base, SZ*SZ); end
    for (int k = 0; k < SZ*SZ && base + k < iss_row.size(); k++) begin
      n_cmp++;
      if (!iss_idle[base+k]) begin n_bad++; $display("FAIL stale_issue_busy[%0d]: got processor ready/busy want idle", k); end
    end
    $display("product stale: first ack cycle %0d, first issue cycle %0d", first_ack,
             (iss_row.size() > base) ? iss_cyc[base] : -1);
  endtask

  task automatic test_mid_start();
    logic [MW-1:0] a, b, exp;
    int base;
    bit ok;
    a = rand_mat(); b = rand_mat(); exp = ref_product(a, b);
    base = iss_row.size();
    start_product(a, b);
    wait_issues(base + 5, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL midstart_wait: got timeout want 5 issues"); end
    @(negedge clk);
    mat_a = rand_mat(); mat_b = rand_mat(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL midstart_done: got timeout want out_done"); end
    for (int n = 0; n < SZ*SZ; n++) begin
      n_cmp++;
      if (mat_c[n*CW +: CW] !== exp[n*CW +: CW]) begin
        n_bad++;
        $display("FAIL midstart_c(%0d,%0d): got %h want %h", n/SZ, n%SZ, mat_c[n*CW +: CW], exp[n*CW +: CW]);
      end
    end
    release_done(ok);
    n_cmp++; if (iss_row.size() - base != SZ*SZ) begin n_bad++; $display("FAIL midstart_issue_count: got %0d want %0d", iss_row.size() - base, SZ*SZ); end
    for (int k = 0; k < SZ*SZ && base + k < iss_row.size(); k++) begin
      n_cmp++;
      if (iss_row[base+k] !== exp_row(a, k/SZ) || iss_col[base+k] !== exp_col(b, k%SZ)) begin
        n_bad++;
        $display("FAIL midstart_order[%0d]: got row %h col %h want row %h col %h", k,
                 iss_row[base+k], iss_col[base+k], exp_row(a, k/SZ), exp_col(b, k%SZ));
      end
    end
    $display("product midstart: %0d issues, extra start ignored", iss_row.size() - base);
  endtask

  task automatic test_reset_mid();
    logic [MW-1:0] a, b, exp;
    int base;
    bit ok;
    a = rand_mat(); b = rand_mat();
    base = iss_row.size();
    start_product(a, b);
    wait_issues(base + 7, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_wait: got timeout want issue of cell (1,2)"); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (mat_c !== '0)      begin n_bad++; $display("FAIL rstmid_mat_c: got %h want 0", mat_c); end
    n_cmp++; if (done !== 1'b0)     begin n_bad++; $display("FAIL rstmid_done: got %b want 0", done); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_cmp++; if (row_a !== '0)      begin n_bad++; $display("FAIL rstmid_row_a: got %h want 0", row_a); end
    n_cmp++; if (col_b !== '0)      begin n_bad++; $display("FAIL rstmid_col_b: got %h want 0", col_b); end
    n_cmp++; if (pe_ready !== 1'b0) begin n_bad++; $display("FAIL rstmid_pe_ready: got %b want 0", pe_ready); end
    n_cmp++; if (pe_ack !== 1'b0)   begin n_bad++; $display("FAIL rstmid_pe_ack: got %b want 0", pe_ack); end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    a = rand_mat(); b = rand_mat(); exp = ref_product(a, b);
    base = iss_row.size();
    start_product(a, b);
    wait_done(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_done2: got timeout want out_done"); end
    for (int n = 0; n < SZ*SZ; n++) begin
      n_cmp++;
      if (mat_c[n*CW +: CW] !== exp[n*CW +: CW]) begin
        n_bad++;
        $display("FAIL rstmid_c(%0d,%0d): got %h want %h", n/SZ, n%SZ, mat_c[n*CW +: CW], exp[n*CW +: CW]);
      end
    end
    release_done(ok);
    n_cmp++; if (iss_row.size() - base != SZ*SZ) begin n_bad++; $display("FAIL rstmid_issue_count: got %0d want %0d", iss_row.size() - base, SZ*SZ); end
    for (int k = 0; k < SZ*SZ && base + k < iss_row.size(); k++) begin
      n_cmp++;
      if (!iss_idle[base+k]) begin n_bad++; $display("FAIL rstmid_issue_busy[%0d]: got processor ready/busy want idle", k); end
    end
    $display("product after mid-product reset: %0d issues", iss_row.size() - base);
  endtask

  task automatic test_truncate();
    logic [MW-1:0] a, b, exp;
    bit ok;
    a = rand_mat(); b = rand_mat(); exp = ref_product(a, b);
    exp[(SZ*SZ-1)*CW +: CW] = 32'h0000_0001;
    corrupt_base = iss_row.size();
    corrupt_en = 1'b1;
    start_product(a, b);
    wait_done(ok);
    corrupt_en = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL trunc_done: got timeout want out_done"); end
    for (int n = 0; n < SZ*SZ; n++) begin
      n_cmp++;
      if (mat_c[n*CW +: CW] !== exp[n*CW +: CW]) begin
        n_bad++;
        $display("FAIL trunc_c(%0d,%0d): got %h want %h", n/SZ, n%SZ, mat_c[n*CW +: CW], exp[n*CW +: CW]);
      end
    end
    release_done(ok);
    $display("product truncate: C(3,3)=%h", mat_c[(SZ*SZ-1)*CW +: CW]);
  endtask

  task automatic test_random();
    logic [MW-1:0] a, b, exp;
    int dly;
    bit ok;
    for (int p = 0; p < 3; p++) begin
      a = rand_mat(); b = rand_mat(); exp = ref_product(a, b);
      dly = $urandom_range(4, 0);
      start_product(a, b);
      wait_done(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL random%0d_done: got timeout want out_done", p); end
      repeat (dly) @(negedge clk);
      for (int n = 0; n < SZ*SZ; n++) begin
        n_cmp++;
        if (mat_c[n*CW +: CW] !== exp[n*CW +: CW]) begin
          n_bad++;
          $display("FAIL random%0d_c(%0d,%0d): got %h want %h", p, n/SZ, n%SZ, mat_c[n*CW +: CW], exp[n*CW +: CW]);
        end
      end
      release_done(ok);
      n_cmp++; if (!ok || busy !== 1'b0) begin n_bad++; $display("FAIL random%0d_release: got busy %b want 0", p, busy); end
      $display("product random %0d: ack delay %0d", p, dly);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_const_ack_delay();
    test_stale_ready();
    test_mid_start();
    test_reset_mid();
    test_truncate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
